// File: rtl/lc3_mem_access.sv
// Memory-access sequencer for the LC3 controller: turns memory states into a
// req/ack transaction, captures read data and pulses `complete` once per access.
module lc3_mem_access #(
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned DATA_W         = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8,
    parameter logic [3:0]  ST_FETCH       = 4'd1,
    parameter logic [3:0]  ST_IND         = 4'd10,
    parameter logic [3:0]  ST_READ        = 4'd11,
    parameter logic [3:0]  ST_WRITE       = 4'd12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [3:0]        state,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] eff_addr,
    input  logic [DATA_W-1:0] store_data,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              complete,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] rdata_out,
    output logic              timeout_err
);

    // state  | meaning
    // S_IDLE | no access in flight, waiting for a memory state
    // S_WAIT | mem_req asserted, waiting for ack / timeout / abort
    // S_DONE | access finished, complete high this cycle
    // S_HOLD | waiting for the controller to leave the serviced state
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_HOLD} fsm_t;

    fsm_t              fsm, fsm_next;
    logic [3:0]        svc_state;
    logic [CNT_W-1:0]  count, count_inc;
    logic              ind_valid;
    logic [ADDR_W-1:0] ind_ptr;
    logic              is_mem, start, got_ack, timed_out, aborted;
    logic [ADDR_W-1:0] start_addr;
    logic              svc_is_read;

    assign is_mem = (state == ST_FETCH) || (state == ST_IND) ||
                    (state == ST_READ)  || (state == ST_WRITE);
    assign count_inc   = count + CNT_W'(1);
    assign svc_is_read = (svc_state != ST_WRITE);

    always_comb begin
        fsm_next   = fsm;
        start      = 1'b0;
        got_ack    = 1'b0;
        timed_out  = 1'b0;
        aborted    = 1'b0;
        start_addr = ind_valid ? ind_ptr : eff_addr;
        if (state == ST_FETCH)
            start_addr = pc;
        else if (state == ST_IND)
            start_addr = eff_addr;
        unique case (fsm)
            S_IDLE: begin
                if (is_mem) begin
                    start    = 1'b1;
                    fsm_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_req && mem_ack) begin
                    got_ack  = 1'b1;
                    fsm_next = S_DONE;
                end else if (count_inc == CNT_W'(TIMEOUT_CYCLES)) begin
                    timed_out = 1'b1;
                    fsm_next  = S_DONE;
                end else if (state != svc_state) begin
                    aborted  = 1'b1;
                    fsm_next = S_IDLE;
                end
            end
            S_DONE: fsm_next = S_HOLD;
            S_HOLD: begin
                if (state != svc_state)
                    fsm_next = S_IDLE;
            end
            default: fsm_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm         <= S_IDLE;
            svc_state   <= 4'd0;
            count       <= '0;
            ind_valid   <= 1'b0;
            ind_ptr     <= '0;
            complete    <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            rdata_out   <= '0;
            timeout_err <= 1'b0;
        end else begin
            fsm      <= fsm_next;
            complete <= (fsm_next == S_DONE);
            if (start) begin
                mem_req   <= 1'b1;
                mem_we    <= (state == ST_WRITE);
                mem_addr  <= start_addr;
                svc_state <= state;
                count     <= '0;
                if (state == ST_WRITE)
                    mem_wdata <= store_data;
                if (state == ST_FETCH)
                    ind_valid <= 1'b0;
            end
            if (fsm == S_WAIT && fsm_next == S_WAIT)
                count <= count_inc;
            if (got_ack) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
                if (svc_is_read)
                    rdata_out <= mem_rdata;
                // the pointer fetched here redirects the next load/store
                if (svc_state == ST_IND) begin
                    ind_ptr   <= mem_rdata;
                    ind_valid <= 1'b1;
                end
            end
            if (timed_out) begin
                mem_req     <= 1'b0;
                mem_we      <= 1'b0;
                timeout_err <= 1'b1;
                if (svc_is_read)
                    rdata_out <= '0;
            end
            if (aborted) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lc3_mem_access.sv
// Directed bench for lc3_mem_access: vector table of single accesses plus
// hand-written hold-guard, timeout and mid-access reset sequences.
module tb_lc3_mem_access;
    localparam logic [3:0] ST_NONE  = 4'd0;
    localparam logic [3:0] ST_FETCH = 4'd1;
    localparam logic [3:0] ST_IND   = 4'd10;
    localparam logic [3:0] ST_READ  = 4'd11;
    localparam logic [3:0] ST_WRITE = 4'd12;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  state = ST_NONE;
    logic [15:0] pc = '0, eff_addr = '0, store_data = '0, mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        complete, mem_req, mem_we, timeout_err;
    logic [15:0] mem_addr, mem_wdata, rdata_out;

    int errors = 0;
    int checks = 0;

    lc3_mem_access #(
        .ADDR_W(16), .DATA_W(16), .TIMEOUT_CYCLES(255), .CNT_W(8),
        .ST_FETCH(ST_FETCH), .ST_IND(ST_IND), .ST_READ(ST_READ), .ST_WRITE(ST_WRITE)
    ) dut (
        .clock(clock), .reset(reset), .state(state), .pc(pc),
        .eff_addr(eff_addr), .store_data(store_data), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .complete(complete), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .rdata_out(rdata_out), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  st;
        logic [15:0] pc;
        logic [15:0] ea;
        logic [15:0] sd;
        logic [15:0] rd;
        int          waits;
        logic [15:0] exp_addr;
        logic        exp_we;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic run_access(input vec_t v, input int idx);
        int cyc = 0, req_cyc = 0, pulses = 0, first_req = -1, cmp_cyc = -1, unstable = 0;
        logic [15:0] a = '0, wd = '0;
        logic w = 1'b0;
        state = v.st; pc = v.pc; eff_addr = v.ea; store_data = v.sd;
        while (cyc < 400 && (cmp_cyc < 0 || cyc < cmp_cyc + 4)) begin
            step();
            cyc++;
            mem_ack = 1'b0;
            if (mem_req) begin
                req_cyc++;
                if (first_req < 0) begin
                    first_req = cyc; a = mem_addr; w = mem_we; wd = mem_wdata;
                end else if (mem_addr !== a || mem_we !== w || mem_wdata !== wd) begin
                    unstable++;
                end
                if (req_cyc == v.waits + 1) begin
                    mem_ack = 1'b1;
                    mem_rdata = v.rd;
                end
            end
            if (complete) begin
                pulses++;
                if (cmp_cyc < 0) cmp_cyc = cyc;
                state = ST_NONE;
            end
        end
        mem_ack = 1'b0;
        state = ST_NONE;
        check($sformatf("v%0d req_seen", idx), (first_req >= 0), 1);
        check($sformatf("v%0d mem_addr", idx), a, v.exp_addr);
        check($sformatf("v%0d mem_we", idx), w, v.exp_we);
        if (v.exp_we) check($sformatf("v%0d mem_wdata", idx), wd, v.sd);
        check($sformatf("v%0d req_stable", idx), unstable, 0);
        check($sformatf("v%0d req_cycles", idx), req_cyc, v.waits + 1);
        check($sformatf("v%0d complete_pulses", idx), pulses, 1);
        check($sformatf("v%0d latency", idx), cmp_cyc - first_req, v.waits + 1);
        check($sformatf("v%0d rdata_out", idx), rdata_out, v.exp_rdata);
    endtask

    initial begin
        int reqs, pulses, cyc, cmp_cyc;
        vec_t tv;

        vecs[0] = '{ST_FETCH, 16'h3000, 16'h0000, 16'h0000, 16'h1234, 0, 16'h3000, 1'b0, 16'h1234};
        vecs[1] = '{ST_WRITE, 16'h3001, 16'h4000, 16'hBEEF, 16'h9999, 3, 16'h4000, 1'b1, 16'h1234};
        vecs[2] = '{ST_IND,   16'h3001, 16'h5000, 16'h0000, 16'h6000, 1, 16'h5000, 1'b0, 16'h6000};
        vecs[3] = '{ST_READ,  16'h3001, 16'h7777, 16'h0000, 16'h00AA, 0, 16'h6000, 1'b0, 16'h00AA};
        vecs[4] = '{ST_WRITE, 16'h3001, 16'h7777, 16'h5A5A, 16'h0000, 2, 16'h6000, 1'b1, 16'h00AA};
        vecs[5] = '{ST_FETCH, 16'h3001, 16'h7777, 16'h0000, 16'hABCD, 1, 16'h3001, 1'b0, 16'hABCD};
        vecs[6] = '{ST_READ,  16'h3002, 16'h8000, 16'h0000, 16'h0F0F, 0, 16'h8000, 1'b0, 16'h0F0F};

        #12;
        check("rst complete", complete, 0);
        check("rst mem_req", mem_req, 0);
        check("rst mem_addr", mem_addr, 0);
        check("rst rdata_out", rdata_out, 0);
        check("rst timeout_err", timeout_err, 0);
        step();
        reset = 1'b0;
        step();

        for (int i = 0; i < 7; i++) run_access(vecs[i], i);

        // hold guard: controller stays in READ_MEM after complete
        state = ST_READ; eff_addr = 16'h8100;
        step();
        check("hold req_rise", mem_req, 1);
        mem_ack = 1'b1; mem_rdata = 16'h1111;
        step();
        check("hold complete", complete, 1);
        check("hold rdata_out", rdata_out, 16'h1111);
        mem_rdata = 16'hDEAD;
        reqs = 0; pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (mem_req) reqs++;
            if (complete) pulses++;
        end
        mem_ack = 1'b0;
        check("hold no_req", reqs, 0);
        check("hold no_complete", pulses, 0);
        check("hold ack_ignored", rdata_out, 16'h1111);
        state = ST_NONE;
        step();
        step();
        check("hold idle_req", mem_req, 0);
        state = ST_READ;
        step();
        check("hold rearm_req", mem_req, 1);
        check("hold rearm_addr", mem_addr, 16'h8100);
        mem_ack = 1'b1; mem_rdata = 16'h2222;
        step();
        mem_ack = 1'b0; state = ST_NONE;
        step();
        step();

        // timeout
        state = ST_READ; eff_addr = 16'h9000;
        reqs = 0; pulses = 0; cyc = 0; cmp_cyc = -1;
        while (cyc < 300 && (cmp_cyc < 0 || cyc < cmp_cyc + 3)) begin
            step();
            cyc++;
            if (mem_req) reqs++;
            if (mem_req && reqs == 1) check("to mem_addr", mem_addr, 16'h9000);
            if (complete) begin
                pulses++;
                if (cmp_cyc < 0) cmp_cyc = cyc;
                state = ST_NONE;
            end
        end
        state = ST_NONE;
        check("to req_cycles", reqs, 255);
        check("to complete_pulses", pulses, 1);
        check("to rdata_out", rdata_out, 0);
        check("to timeout_err", timeout_err, 1);
        tv = '{ST_FETCH, 16'h3100, 16'h0000, 16'h0000, 16'h4321, 0, 16'h3100, 1'b0, 16'h4321};
        run_access(tv, 7);
        check("to sticky", timeout_err, 1);

        // reset in the middle of an access
        state = ST_FETCH; pc = 16'h3200;
        step();
        check("mid req_before", mem_req, 1);
        #2 reset = 1'b1;
        #1;
        check("mid mem_req", mem_req, 0);
        check("mid mem_addr", mem_addr, 0);
        check("mid complete", complete, 0);
        check("mid timeout_err", timeout_err, 0);
        check("mid rdata_out", rdata_out, 0);
        state = ST_NONE;
        step();
        reset = 1'b0;
        reqs = 0; pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (mem_req) reqs++;
            if (complete) pulses++;
        end
        check("mid no_complete", pulses, 0);
        check("mid no_req", reqs, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lc3_mem_access.md
Name: lc3_mem_access

Overview:
- Memory-access sequencer directly downstream of the LC3 controller's state output; it produces the controller's `complete` input.
- Decodes the controller state, drives a req/ack handshake to the memory port, and captures read data for decode/register-file writeback.
- Handles indirect addressing: the pointer read in INDIRECT_ADDR_READ becomes the address of the following READ_MEM/WRITE_MEM.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- TIMEOUT_CYCLES, 255, max cycles waiting for mem_ack before forced completion.
- CNT_W, 8, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- state  in  4  controller current state; shared LC3 state codes.
- pc  in  ADDR_W  current PC (fetch address).
- eff_addr  in  ADDR_W  computed memory address from COMPUTE_MEM_ADRR.
- store_data  in  DATA_W  data for WRITE_MEM.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
- mem_ack  in  1  memory acknowledge; ignored unless mem_req=1.
- complete  out  1  one-cycle pulse to controller: access finished.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  1=write, 0=read; valid while mem_req=1.
- mem_addr  out  ADDR_W  request address, stable while mem_req=1.
- mem_wdata  out  DATA_W  write data, stable while mem_req=1.
- rdata_out  out  DATA_W  last captured read data (instruction, pointer, or load value).
- timeout_err  out  1  sticky: an access timed out.

Behaviour:
- Reset (async): internal FSM=IDLE; complete=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata_out=0, timeout_err=0, ind_valid=0, ind_ptr=0, count=0. All outputs registered.
- Memory states: FETCH_INSTRUCTION, INDIRECT_ADDR_READ, READ_MEM, WRITE_MEM. All other states are non-memory.
- Internal FSM: IDLE, WAIT, DONE, HOLD.
- IDLE, state is a memory state → WAIT. Set mem_req=1, latch svc_state=state, count=0. Address and direction:
  - FETCH_INSTRUCTION: address = pc, read; also clear ind_valid.
  - INDIRECT_ADDR_READ: address = eff_addr, read.
  - READ_MEM: address = ind_valid ? ind_ptr : eff_addr, read.
  - WRITE_MEM: same address select, mem_we=1, mem_wdata=store_data.
- WAIT:
  - mem_ack=1: drop mem_req and mem_we, rdata_out<=mem_rdata (reads only), → DONE.
  - If svc_state=INDIRECT_ADDR_READ on ack: ind_ptr<=mem_rdata, ind_valid<=1.
  - No ack: count increments. When count reaches TIMEOUT_CYCLES: drop mem_req, timeout_err<=1, rdata_out<=0 for reads, → DONE.
  - state ≠ svc_state (abort): drop mem_req, → IDLE, no complete.
- DONE: complete=1 for exactly this cycle, → HOLD.
- HOLD: complete=0; return to IDLE only when state ≠ svc_state. This prevents double-servicing while the controller is still in the old state.
- Latency: state enters a memory state at edge N → mem_req high after edge N+1. mem_ack sampled at edge M → complete and rdata_out valid after edge M+1. A zero-wait memory (ack on first req cycle) gives complete two cycles after state entry.
- Back-to-back accesses: INDIRECT_ADDR_READ→READ_MEM/WRITE_MEM passes through HOLD for one cycle, then starts the new access using ind_ptr.
- mem_ack while mem_req=0 is ignored.
- timeout_err is cleared only by reset.
- Reset asserted mid-access: mem_req drops immediately (async), no complete is issued.

Test Plan:
- Fetch, 0-wait: reset, state=FETCH, pc=16'h3000, ack on first req cycle with rdata=16'h1234 → mem_addr=3000, mem_we=0; one complete pulse 2 cycles after state entry; rdata_out=1234.
- Write, 3 wait cycles: state=WRITE_MEM, eff_addr=16'h4000, store_data=16'hBEEF → mem_req held 4 cycles, mem_we=1, mem_wdata=BEEF; complete one cycle after ack; single pulse.
- Indirect load: INDIRECT_ADDR_READ, eff_addr=16'h5000, ack data 16'h6000; then READ_MEM, ack data 16'h00AA → second mem_addr=6000; rdata_out=00AA; two complete pulses.
- Timeout: state=READ_MEM, never ack, TIMEOUT_CYCLES=255 → mem_req drops after 255 wait cycles; complete pulses; rdata_out=0; timeout_err=1 sticky until reset.
- Reset mid-access: assert reset while mem_req=1 → mem_req=0 and all outputs at reset values with no clock edge; no complete after reset release.
- Hold guard: keep state=READ_MEM for 5 cycles after complete → no second mem_req until state changes.
